// File: rtl/hermes_local_tx_if.sv
// Processor-side (FIFO load, send request) and router-link (tx/data/credit) signals
// of the Hermes local-port packet injector.
interface hermes_local_tx_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic                  wr_en;
    logic [FLIT_WIDTH-1:0] wr_data;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic                  send_req;
    logic [15:0]           send_dest;
    logic [15:0]           send_size;
    logic                  busy;
    logic                  done;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_o;
    logic                  credit_i;
    logic                  clock_tx;

    modport master (
        output wr_en, wr_data, send_req, send_dest, send_size, credit_i,
        input  fifo_full, fifo_count, busy, done, tx, data_o, clock_tx
    );

    modport slave (
        input  wr_en, wr_data, send_req, send_dest, send_size, credit_i,
        output fifo_full, fifo_count, busy, done, tx, data_o, clock_tx
    );
endinterface

// File: rtl/hermes_local_tx.sv
// Hermes local-port injector: payload FIFO plus header/size/payload serialiser on the
// credit-based router link. Optional timestamp flit enabled by HERMES_LOCAL_TX_TIMESTAMP_EN.
module hermes_local_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input logic              clock,
    input logic              reset,
    hermes_local_tx_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
    typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, TSTAMP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [15:0]           dest_q, dest_d;
    logic [15:0]           remaining_q, remaining_d;
    logic                  tx_q, tx_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;

    logic [FLIT_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, wrPtr_q, headPtr;
    logic [CNT_W-1:0]      count_q, count_d, countAfterPop;
    logic                  full, xfer, pop, push, headValid;
    logic [FLIT_WIDTH-1:0] headFlit, sizeFlit;
    logic [15:0]           sizeField;

    assign full          = (count_q == CNT_W'(FIFO_DEPTH));
    assign xfer          = tx_q && bus.credit_i;
    assign pop           = (state_q == PAYLOAD) && xfer;
    assign push          = bus.wr_en && (!full || pop);
    assign headPtr       = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    assign countAfterPop = count_q - CNT_W'(pop);
    assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    // An empty FIFO that receives a word on this edge presents that word directly.
    assign headValid     = (countAfterPop != '0) || push;
    assign headFlit      = (countAfterPop == '0) ? bus.wr_data : fifoMem[headPtr];

`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
    logic [FLIT_WIDTH-1:0] tsCnt_q, tsCap_q, tsCap_d;

    assign sizeField = remaining_q + 16'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tsCnt_q <= '0;
        else        tsCnt_q <= tsCnt_q + FLIT_WIDTH'(1);
    end
`else
    assign sizeField = remaining_q;
`endif
    assign sizeFlit = FLIT_WIDTH'(sizeField);

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr_q] <= bus.wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= headPtr;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            remaining_q <= '0;
            tx_q        <= 1'b0;
            data_q      <= '0;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
            tsCap_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            remaining_q <= remaining_d;
            tx_q        <= tx_d;
            data_q      <= data_d;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
            tsCap_q     <= tsCap_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        remaining_d = remaining_q;
        tx_d        = tx_q;
        data_d      = data_q;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
        tsCap_d     = tsCap_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.send_req) begin
                    state_d     = HEADER;
                    dest_d      = bus.send_dest;
                    remaining_d = bus.send_size;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
                    tsCap_d     = tsCnt_q;
`endif
                end
            end
            HEADER: begin
                if (!tx_q) begin
                    tx_d   = 1'b1;
                    data_d = FLIT_WIDTH'(dest_q);
                end else if (xfer) begin
                    state_d = SIZE;
                    data_d  = sizeFlit;
                end
            end
            SIZE: begin
                if (xfer) begin
                    if (remaining_q != '0) begin
                        state_d = PAYLOAD;
                        tx_d    = headValid;
                        if (headValid) data_d = headFlit;
                    end else begin
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
                        state_d = TSTAMP;
                        data_d  = tsCap_q;
`else
                        state_d = DONE;
                        tx_d    = 1'b0;
`endif
                    end
                end
            end
            PAYLOAD: begin
                // The output register reloads whenever it is empty or its flit just left.
                if (xfer && remaining_q == 16'd1) begin
                    remaining_d = '0;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
                    state_d = TSTAMP;
                    data_d  = tsCap_q;
`else
                    state_d = DONE;
                    tx_d    = 1'b0;
`endif
                end else if (xfer || !tx_q) begin
                    if (xfer) remaining_d = remaining_q - 16'd1;
                    tx_d = headValid;
                    if (headValid) data_d = headFlit;
                end
            end
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
            TSTAMP: begin
                if (xfer) begin
                    state_d = DONE;
                    tx_d    = 1'b0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_full  = full;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.done       = (state_q == DONE);
    assign bus.tx         = tx_q;
    assign bus.data_o     = data_q;
    assign bus.clock_tx   = clock;
endmodule

// File: tb/tb_hermes_local_tx.sv
// Bench for hermes_local_tx: directed scenarios and randomized packets compared against a
// queue model of the payload FIFO and the header/size/payload packet format.
module tb_hermes_local_tx;
    localparam int FW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
    localparam int TS = 1;
`else
    localparam int TS = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   assertCount = 0;
    int   failCount = 0;
    int   tbCycle;

    // Model state and per-packet traces
    logic [FW-1:0] modelQ[$];
    logic [FW-1:0] expQ[$];
    logic [FW-1:0] flitQ[$];
    logic [FW-1:0] dataTrace[$];
    logic          txTrace[$];
    logic          creditTrace[$];
    logic [FW-1:0] lateWords[$];
    logic [FW-1:0] expTs;

    hermes_local_tx_if #(.FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) bus ();

    hermes_local_tx #(.FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Cycles since reset release, matching the free-running timestamp counter
    always @(posedge clock or negedge reset) begin
        if (!reset) tbCycle <= 0;
        else        tbCycle <= tbCycle + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pushWord(input logic [FW-1:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        step();
        bus.wr_en   = 1'b0;
        if (modelQ.size() < DEPTH) modelQ.push_back(w);
    endtask

    // Packet format: header = dest, size flit, first `size` queued words, optional timestamp
    task automatic buildExpected(input logic [15:0] dest, input logic [15:0] size);
        logic [15:0] sf;
        expQ.delete();
        sf = size + 16'(TS);
        expQ.push_back(FW'(dest));
        expQ.push_back(FW'(sf));
        for (int i = 0; i < int'(size); i++)
            if (modelQ.size() > 0) expQ.push_back(modelQ.pop_front());
        if (TS == 1) expQ.push_back(expTs);
    endtask

    // Issues one request and records link activity until done (c = edges after the request edge)
    task automatic sendPacket(input logic [15:0] dest, input logic [15:0] size,
                              input logic [FW-1:0] stallVal, input int stallLen,
                              input bit randCredit, input int extraReqCycle,
                              input int lateCycle, output int doneCycle, output bit timedOut);
        int c;
        int stallLeft;
        flitQ.delete(); dataTrace.delete(); txTrace.delete(); creditTrace.delete();
        doneCycle = -1;
        timedOut  = 1'b0;
        stallLeft = stallLen;
        expTs     = FW'(tbCycle);
        bus.send_dest = dest;
        bus.send_size = size;
        bus.send_req  = 1'b1;
        step();
        bus.send_req = 1'b0;
        c = 0;
        while (1) begin
            txTrace.push_back(bus.tx);
            dataTrace.push_back(bus.data_o);
            if (bus.done) begin
                doneCycle = c;
                creditTrace.push_back(1'b1);
                break;
            end
            if (c == extraReqCycle) begin
                bus.send_req  = 1'b1;
                bus.send_dest = ~dest;
                bus.send_size = size + 16'd3;
            end
            if (lateCycle >= 0 && c >= lateCycle && lateWords.size() > 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = lateWords.pop_front();
                modelQ.push_back(bus.wr_data);
            end else begin
                bus.wr_en = 1'b0;
            end
            bus.credit_i = randCredit ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.tx && bus.data_o == stallVal && stallLeft > 0) begin
                bus.credit_i = 1'b0;
                stallLeft--;
            end
            creditTrace.push_back(bus.credit_i);
            if (bus.tx && bus.credit_i) flitQ.push_back(bus.data_o);
            step();
            bus.send_req = 1'b0;
            c++;
            if (c > 3000) begin
                timedOut = 1'b1;
                break;
            end
        end
        bus.wr_en    = 1'b0;
        bus.credit_i = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        assertCount++; if (bus.tx !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx: got %b expected 0", bus.tx); end
        assertCount++; if (bus.data_o !== '0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 0", bus.data_o); end
        assertCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        assertCount++; if (bus.done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        assertCount++; if (bus.fifo_count !== '0) begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        assertCount++; if (bus.fifo_full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_full: got %b expected 0", bus.fifo_full); end
        reset = 1'b1;
        repeat (2) step();
        assertCount++; if (bus.tx !== 1'b0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_idle: tx=%b busy=%b expected 0/0", bus.tx, bus.busy); end
        assertCount++; if (bus.clock_tx !== clock) begin failCount++; $display("[TB] FAIL clock_tx: got %b expected %b", bus.clock_tx, clock); end
        modelQ.delete();
    endtask

`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
    task automatic test_timestamp();
        int dc;
        bit to;
        int guard;
        pushWord(32'h11); pushWord(32'h22);
        guard = 0;
        while (tbCycle != 100 && guard < 200) begin step(); guard++; end
        assertCount++; if (tbCycle != 100) begin failCount++; $display("[TB] FAIL ts_align: got %0d expected 100", tbCycle); end
        sendPacket(16'h0101, 16'd2, '1, 0, 1'b0, -1, -1, dc, to);
        buildExpected(16'h0101, 16'd2);
        assertCount++; if (flitQ.size() != 5) begin failCount++; $display("[TB] FAIL ts_len: got %0d expected 5", flitQ.size()); end
        else begin
            assertCount++; if (flitQ[1] !== 32'd3) begin failCount++; $display("[TB] FAIL ts_size: got %h expected 3", flitQ[1]); end
            assertCount++; if (flitQ[4] !== 32'd100) begin failCount++; $display("[TB] FAIL ts_value: got %h expected 100", flitQ[4]); end
        end
        assertCount++; if (dc != 6) begin failCount++; $display("[TB] FAIL ts_latency: got %0d expected 6", dc); end
    endtask
`endif

    task automatic test_basic_send();
        int dc;
        bit to;
        for (int i = 0; i < 4; i++) pushWord(FW'(32'hA1 + i));
        assertCount++; if (bus.fifo_count !== CW'(4)) begin failCount++; $display("[TB] FAIL basic_count_load: got %0d expected 4", bus.fifo_count); end
        sendPacket(16'h0201, 16'd4, '1, 0, 1'b0, -1, -1, dc, to);
        buildExpected(16'h0201, 16'd4);
        assertCount++; if (to) begin failCount++; $display("[TB] FAIL basic_timeout: got timeout expected done"); end
        assertCount++; if (txTrace.size() < 1 || txTrace[0] !== 1'b0) begin failCount++; $display("[TB] FAIL basic_first_cycle: tx should be 0 on the request edge"); end
        for (int i = 0; i < expQ.size(); i++) begin
            assertCount++;
            if (txTrace.size() <= i + 1 || txTrace[i+1] !== 1'b1 || dataTrace[i+1] !== expQ[i]) begin
                failCount++;
                $display("[TB] FAIL basic_flit%0d: got %h expected %h", i, (dataTrace.size() > i + 1) ? dataTrace[i+1] : 'x, expQ[i]);
            end
        end
        assertCount++; if (dc != expQ.size() + 1) begin failCount++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", dc, expQ.size() + 1); end
        assertCount++; if (bus.fifo_count !== '0) begin failCount++; $display("[TB] FAIL basic_count_end: got %0d expected 0", bus.fifo_count); end
        step();
        assertCount++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_after_done: done=%b busy=%b expected 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_backpressure();
        int dc;
        bit to;
        for (int i = 0; i < 4; i++) pushWord(FW'(32'hA1 + i));
        sendPacket(16'h0201, 16'd4, 32'hA2, 3, 1'b0, -1, -1, dc, to);
        buildExpected(16'h0201, 16'd4);
        assertCount++; if (dc != 10 + TS) begin failCount++; $display("[TB] FAIL bp_done_cycle: got %0d expected %0d", dc, 10 + TS); end
        for (int c = 4; c <= 7; c++) begin
            assertCount++;
            if (txTrace.size() <= c || txTrace[c] !== 1'b1 || dataTrace[c] !== 32'hA2) begin
                failCount++;
                $display("[TB] FAIL bp_hold_c%0d: got %h expected a2 with tx=1", c, (dataTrace.size() > c) ? dataTrace[c] : 'x);
            end
        end
        assertCount++; if (dataTrace.size() <= 8 || dataTrace[8] !== 32'hA3) begin failCount++; $display("[TB] FAIL bp_next: expected a3 after the stall"); end
        assertCount++; if (flitQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL bp_len: got %0d expected %0d", flitQ.size(), expQ.size()); end
        else for (int i = 0; i < expQ.size(); i++) begin
            assertCount++; if (flitQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL bp_flit%0d: got %h expected %h", i, flitQ[i], expQ[i]); end
        end
    endtask

    task automatic test_underrun();
        int dc;
        bit to;
        pushWord(32'hB1);
        lateWords.delete();
        lateWords.push_back(32'hB2);
        lateWords.push_back(32'hB3);
        sendPacket(16'h0403, 16'd3, '1, 0, 1'b0, -1, 5, dc, to);
        buildExpected(16'h0403, 16'd3);
        assertCount++; if (txTrace.size() < 6 || txTrace[4] !== 1'b0 || txTrace[5] !== 1'b0) begin failCount++; $display("[TB] FAIL underrun_gap: tx should stay 0 while the FIFO is empty"); end
        assertCount++; if (flitQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL underrun_len: got %0d expected %0d", flitQ.size(), expQ.size()); end
        else for (int i = 0; i < expQ.size(); i++) begin
            assertCount++; if (flitQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL underrun_flit%0d: got %h expected %h", i, flitQ[i], expQ[i]); end
        end
        assertCount++; if (dc != 8 + TS) begin failCount++; $display("[TB] FAIL underrun_done: got %0d expected %0d", dc, 8 + TS); end
    endtask

    task automatic test_full_zero();
        int dc;
        bit to;
        for (int i = 0; i <= DEPTH; i++) pushWord(FW'(32'hC0 + i));
        assertCount++; if (bus.fifo_count !== CW'(DEPTH)) begin failCount++; $display("[TB] FAIL full_count: got %0d expected %0d", bus.fifo_count, DEPTH); end
        assertCount++; if (bus.fifo_full !== 1'b1) begin failCount++; $display("[TB] FAIL full_flag: got %b expected 1", bus.fifo_full); end
        sendPacket(16'h0305, 16'd0, '1, 0, 1'b0, 1, -1, dc, to);
        buildExpected(16'h0305, 16'd0);
        assertCount++; if (dc != 3 + TS) begin failCount++; $display("[TB] FAIL zero_done: got %0d expected %0d", dc, 3 + TS); end
        assertCount++; if (flitQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL zero_len: got %0d expected %0d", flitQ.size(), expQ.size()); end
        else for (int i = 0; i < expQ.size(); i++) begin
            assertCount++; if (flitQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL zero_flit%0d: got %h expected %h", i, flitQ[i], expQ[i]); end
        end
        assertCount++; if (bus.fifo_count !== CW'(DEPTH)) begin failCount++; $display("[TB] FAIL zero_untouched: got %0d expected %0d", bus.fifo_count, DEPTH); end
        for (int i = 0; i < 5; i++) begin
            step();
            assertCount++; if (bus.tx !== 1'b0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL busy_req_ignored: tx=%b busy=%b expected 0/0", bus.tx, bus.busy); end
        end
        sendPacket(16'h0102, 16'(DEPTH), '1, 0, 1'b0, -1, -1, dc, to);
        buildExpected(16'h0102, 16'(DEPTH));
        assertCount++; if (flitQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL drain_len: got %0d expected %0d", flitQ.size(), expQ.size()); end
        else for (int i = 0; i < expQ.size(); i++) begin
            assertCount++; if (flitQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL drain_flit%0d: got %h expected %h", i, flitQ[i], expQ[i]); end
        end
        assertCount++; if (bus.fifo_count !== '0 || bus.fifo_full !== 1'b0) begin failCount++; $display("[TB] FAIL drain_empty: count=%0d full=%b expected 0/0", bus.fifo_count, bus.fifo_full); end
    endtask

    task automatic test_reset_mid();
        int n;
        int guard;
        for (int i = 0; i < 5; i++) pushWord(FW'(32'hD0 + i));
        bus.send_dest = 16'h0506;
        bus.send_size = 16'd5;
        bus.send_req  = 1'b1;
        step();
        bus.send_req = 1'b0;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 50) begin
            if (bus.tx && bus.credit_i) n++;
            step();
            guard++;
        end
        assertCount++; if (n != 4) begin failCount++; $display("[TB] FAIL mid_reach: got %0d flits expected 4", n); end
        reset = 1'b0;
        #1;
        assertCount++; if (bus.tx !== 1'b0) begin failCount++; $display("[TB] FAIL mid_tx: got %b expected 0", bus.tx); end
        assertCount++; if (bus.fifo_count !== '0) begin failCount++; $display("[TB] FAIL mid_count: got %0d expected 0", bus.fifo_count); end
        assertCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL mid_busy: got %b expected 0", bus.busy); end
        step();
        reset = 1'b1;
        modelQ.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            assertCount++; if (bus.tx !== 1'b0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL mid_stray: tx=%b busy=%b expected 0/0", bus.tx, bus.busy); end
        end
    endtask

    task automatic test_random();
        int dc;
        bit to;
        int n;
        logic [15:0] size;
        logic [15:0] dest;
        bit rc;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, DEPTH - modelQ.size());
            for (int i = 0; i < n; i++) pushWord($urandom);
            size = 16'($urandom_range(0, modelQ.size()));
            dest = 16'($urandom);
            rc   = it[0];
            sendPacket(dest, size, '1, 0, rc, -1, -1, dc, to);
            buildExpected(dest, size);
            assertCount++; if (to) begin failCount++; $display("[TB] FAIL rand%0d_timeout: got timeout expected done", it); end
            assertCount++; if (flitQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL rand%0d_len: got %0d expected %0d", it, flitQ.size(), expQ.size()); end
            else for (int i = 0; i < expQ.size(); i++) begin
                assertCount++; if (flitQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL rand%0d_flit%0d: got %h expected %h", it, i, flitQ[i], expQ[i]); end
            end
            if (!rc) begin
                assertCount++; if (dc != int'(size) + 3 + TS) begin failCount++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", it, dc, int'(size) + 3 + TS); end
            end
            for (int c = 0; c + 1 < txTrace.size(); c++) begin
                if (txTrace[c] && !creditTrace[c]) begin
                    assertCount++;
                    if (txTrace[c+1] !== 1'b1 || dataTrace[c+1] !== dataTrace[c]) begin
                        failCount++;
                        $display("[TB] FAIL rand%0d_hold_c%0d: got %h expected %h held", it, c, dataTrace[c+1], dataTrace[c]);
                    end
                end
            end
            assertCount++; if (bus.fifo_count !== CW'(modelQ.size())) begin failCount++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, bus.fifo_count, modelQ.size()); end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.send_req  = 1'b0;
        bus.send_dest = '0;
        bus.send_size = '0;
        bus.credit_i  = 1'b1;
        test_reset();
`ifdef HERMES_LOCAL_TX_TIMESTAMP_EN
        test_timestamp();
`endif
        test_basic_send();
        test_backpressure();
        test_underrun();
        test_full_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
